// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: sequencer and two-way arbiter for the shared shift-add
// N x N multiplier datapath. Grants one requester, drives the datapath
// strobes through N add/shift iterations, then pulses done to the winner.
// Build option: define MULT_FIXED_PRIO_EN to make requester 0 win every tie
// (no last-winner pointer); otherwise ties alternate round robin.
module mult_share_ctrl #(
   parameter int N     = 4,
   parameter int CNT_W = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       mplr_lsb,
   output logic [1:0] gnt,
   output logic [1:0] done,
   output logic       busy,
   output logic       ld1,
   output logic       sig_rst,
   output logic       ld2,
   output logic       s0,
   output logic       s1,
   output logic       s2
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CLR   = 3'd2,
      CALC  = 3'd3,
      SHIFT = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       gnt_q, gnt_d;
   logic             win;          // index of the requester that wins in IDLE

`ifndef MULT_FIXED_PRIO_EN
   logic             last_q, last_d;
`endif

   // Arbitration: a lone requester wins; a tie is broken by priority scheme
   always_comb begin
      win = 1'b0;
      case (req)
         2'b10:   win = 1'b1;
`ifdef MULT_FIXED_PRIO_EN
         2'b11:   win = 1'b0;
`else
         2'b11:   win = ~last_q;
`endif
         default: win = 1'b0;
      endcase
   end

   // Next-state, grant latch, iteration counter and last-winner pointer
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
`ifndef MULT_FIXED_PRIO_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (|req) begin
               state_d = LOAD;
               gnt_d   = win ? 2'b10 : 2'b01;
            end
         end
         LOAD:  state_d = CLR;
         CLR: begin
            state_d = CALC;
            cnt_d   = '0;
         end
         CALC:  state_d = SHIFT;
         SHIFT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q != CNT_LAST) begin
               state_d = CALC;
            end else begin
               state_d = DONE;
`ifndef MULT_FIXED_PRIO_EN
               last_d  = gnt_q[1];
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter, grant and pointer registers with async reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gnt_q   <= '0;
`ifndef MULT_FIXED_PRIO_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
`ifndef MULT_FIXED_PRIO_EN
         last_q  <= last_d;
`endif
      end
   end

   // Output decode from registered state; ld2 in CALC follows mplr_lsb
   always_comb begin
      gnt     = '0;
      done    = '0;
      busy    = 1'b0;
      ld1     = 1'b0;
      sig_rst = 1'b0;
      ld2     = 1'b0;
      s0      = 1'b0;
      s1      = 1'b0;
      s2      = 1'b0;
      case (state_q)
         LOAD: begin
            gnt  = gnt_q;
            busy = 1'b1;
            ld1  = 1'b1;
         end
         CLR: begin
            gnt     = gnt_q;
            busy    = 1'b1;
            sig_rst = 1'b1;
         end
         CALC: begin
            gnt  = gnt_q;
            busy = 1'b1;
            ld2  = mplr_lsb;
            s0   = 1'b1;
         end
         SHIFT: begin
            gnt  = gnt_q;
            busy = 1'b1;
            ld2  = 1'b1;
            s1   = 1'b1;
            s2   = 1'b1;
         end
         DONE: begin
            gnt  = gnt_q;
            busy = 1'b1;
            done = gnt_q;
         end
         default: ;
      endcase
   end

endmodule
